// File: rtl/stack_alu.sv
// Command sequencer for the operand stack: runs one arithmetic or stack command per
// handshake, reading operands from stk_tos and writing results back through stk_op/stk_data.
module stack_alu #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] imm,
   output logic             ready,
   output logic             done,
   output logic [1:0]       fault,
   output logic [1:0]       stk_op,
   output logic [WIDTH-1:0] stk_data,
   input  logic [WIDTH-1:0] stk_tos,
   input  logic [1:0]       stk_status,
   input  logic [1:0]       stk_error
);

   localparam logic [1:0] OP_NONE = 2'd0, OP_PUSH = 2'd1, OP_POP = 2'd2, OP_REPL = 2'd3;
   localparam logic [1:0] ST_EMPTY = 2'd1, ST_FULL = 2'd2;
   localparam logic [1:0] F_NONE = 2'd0, F_UNDER = 2'd1, F_OVER = 2'd2, F_ILLEGAL = 2'd3;
   localparam logic [3:0] OPC_LT_U = 4'd6, OPC_EQZ = 4'd7, OPC_CONST = 4'd8, OPC_DROP = 4'd9;

   typedef enum logic [1:0] {S_IDLE, S_EXEC1, S_EXEC2, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       opc_q, opc_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       fault_q, fault_d;
   logic             opv_q, opv_d;
   logic [WIDTH-1:0] alu_res;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         opc_q   <= '0;
         imm_q   <= '0;
         b_q     <= '0;
         fault_q <= '0;
         opv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         imm_q   <= imm_d;
         b_q     <= b_d;
         fault_q <= fault_d;
         opv_q   <= opv_d;
      end
   end

   // a is the deeper operand, visible on stk_tos once b has been popped
   always_comb begin
      alu_res = '0;
      case (opc_q)
         4'd0:    alu_res = stk_tos + b_q;
         4'd1:    alu_res = stk_tos - b_q;
         4'd2:    alu_res = stk_tos & b_q;
         4'd3:    alu_res = stk_tos | b_q;
         4'd4:    alu_res = stk_tos ^ b_q;
         4'd5:    alu_res[0] = (stk_tos == b_q);
         4'd6:    alu_res[0] = (stk_tos < b_q);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      opc_d    = opc_q;
      imm_d    = imm_q;
      b_d      = b_q;
      fault_d  = fault_q;
      stk_op   = OP_NONE;
      stk_data = '0;
      ready    = 1'b0;
      done     = 1'b0;
      fault    = F_NONE;
      case (state_q)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               opc_d   = opcode;
               imm_d   = imm;
               fault_d = F_NONE;
               state_d = S_EXEC1;
            end
         end
         S_EXEC1: begin
            state_d = S_DONE;
            if (opc_q <= OPC_LT_U) begin
               if (stk_status == ST_EMPTY) begin
                  fault_d = F_UNDER;
               end else begin
                  b_d     = stk_tos;
                  stk_op  = OP_POP;
                  state_d = S_EXEC2;
               end
            end else if (opc_q == OPC_EQZ) begin
               if (stk_status == ST_EMPTY) begin
                  fault_d = F_UNDER;
               end else begin
                  stk_op      = OP_REPL;
                  stk_data[0] = (stk_tos == '0);
               end
            end else if (opc_q == OPC_CONST) begin
               if (stk_status == ST_FULL) begin
                  fault_d = F_OVER;
               end else begin
                  stk_op   = OP_PUSH;
                  stk_data = imm_q;
               end
            end else if (opc_q == OPC_DROP) begin
               if (stk_status == ST_EMPTY) fault_d = F_UNDER;
               else                        stk_op  = OP_POP;
            end else begin
               fault_d = F_ILLEGAL;
            end
         end
         S_EXEC2: begin
            state_d = S_DONE;
            // Empty after the pop means only one entry existed: put b back
            if (stk_status == ST_EMPTY) begin
               stk_op   = OP_PUSH;
               stk_data = b_q;
               fault_d  = F_UNDER;
            end else begin
               stk_op   = OP_REPL;
               stk_data = alu_res;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            fault   = (opv_q && stk_error != 2'd0) ? stk_error : fault_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      opv_d = (stk_op != OP_NONE);
   end

endmodule

// File: tb/tb_stack_alu.sv
// Directed bench for stack_alu with a 4-deep behavioural operand stack attached.
module tb_stack_alu;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [3:0] opcode = '0;
   logic [7:0] imm = '0;
   logic       ready, done;
   logic [1:0] fault, stk_op;
   logic [7:0] stk_data, stk_tos;
   logic [1:0] stk_status;
   logic [1:0] stk_error;

   int checks = 0;
   int errors = 0;

   stack_alu #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode), .imm(imm),
      .ready(ready), .done(done), .fault(fault), .stk_op(stk_op), .stk_data(stk_data),
      .stk_tos(stk_tos), .stk_status(stk_status), .stk_error(stk_error)
   );

   always #5 clk = ~clk;

   // Operand stack model, depth 4
   logic [7:0] mem [4];
   logic [2:0] cnt;
   logic [1:0] topi;
   assign topi       = 2'(cnt - 3'd1);
   assign stk_tos    = (cnt != 3'd0) ? mem[topi] : 8'd0;
   assign stk_status = (cnt == 3'd0) ? 2'd1 : (cnt == 3'd4) ? 2'd2 : 2'd0;

   always @(posedge clk) begin
      if (reset) begin
         cnt       <= 3'd0;
         stk_error <= 2'd0;
      end else begin
         stk_error <= 2'd0;
         case (stk_op)
            2'd1: if (cnt == 3'd4) stk_error <= 2'd2;
                  else begin mem[cnt[1:0]] <= stk_data; cnt <= cnt + 3'd1; end
            2'd2: if (cnt == 3'd0) stk_error <= 2'd1;
                  else cnt <= cnt - 3'd1;
            2'd3: if (cnt == 3'd0) stk_error <= 2'd1;
                  else mem[topi] <= stk_data;
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      @(negedge clk); reset = 1'b0;
   endtask

   // Pulses start for one cycle; returns at the negedge of cycle N+1
   task automatic issue(input logic [3:0] op, input logic [7:0] im);
      @(negedge clk); start = 1'b1; opcode = op; imm = im;
      @(negedge clk); start = 1'b0;
   endtask

   // Runs a command to completion; lat = cycles from accept to done (bounded)
   task automatic run_cmd(input logic [3:0] op, input logic [7:0] im,
                          output int lat, output logic [1:0] f);
      issue(op, im);
      lat = 1;
      while (done !== 1'b1 && lat < 8) begin
         @(negedge clk); lat++;
      end
      f = fault;
   endtask

   int         lat;
   logic [1:0] f;
   logic       seen;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_fault", fault, 0);
      chk("rst_stk_op", stk_op, 0);
      chk("rst_stk_data", stk_data, 0);

      // ADD 200 + 100
      run_cmd(4'd8, 8'd200, lat, f);
      chk("const200_lat", lat, 2);
      run_cmd(4'd8, 8'd100, lat, f);
      issue(4'd0, 8'd0);
      chk("add_n1_op", stk_op, 2);
      chk("add_n1_data", stk_data, 0);
      chk("add_n1_ready", ready, 0);
      @(negedge clk);
      chk("add_n2_op", stk_op, 3);
      chk("add_n2_data", stk_data, 44);
      @(negedge clk);
      chk("add_n3_done", done, 1);
      chk("add_n3_fault", fault, 0);
      chk("add_n3_ready", ready, 0);
      @(negedge clk);
      chk("add_after_ready", ready, 1);
      chk("add_after_done", done, 0);
      chk("add_cnt", cnt, 1);
      chk("add_tos", stk_tos, 44);

      // SUB, LT_U on [5,9]; EQ on [7,7]
      do_reset();
      run_cmd(4'd8, 8'd5, lat, f); run_cmd(4'd8, 8'd9, lat, f);
      run_cmd(4'd1, 8'd0, lat, f);
      chk("sub_lat", lat, 3);
      chk("sub_fault", f, 0);
      @(negedge clk);
      chk("sub_tos", stk_tos, 252);
      do_reset();
      run_cmd(4'd8, 8'd5, lat, f); run_cmd(4'd8, 8'd9, lat, f);
      run_cmd(4'd6, 8'd0, lat, f);
      @(negedge clk);
      chk("ltu_tos", stk_tos, 1);
      run_cmd(4'd8, 8'd7, lat, f); run_cmd(4'd8, 8'd7, lat, f);
      run_cmd(4'd5, 8'd0, lat, f);
      @(negedge clk);
      chk("eq_tos", stk_tos, 1);
      chk("eq_cnt", cnt, 2);

      // One-entry ADD restores the stack
      do_reset();
      run_cmd(4'd8, 8'd3, lat, f);
      issue(4'd0, 8'd0);
      chk("one_n1_op", stk_op, 2);
      @(negedge clk);
      chk("one_n2_op", stk_op, 1);
      chk("one_n2_data", stk_data, 3);
      @(negedge clk);
      chk("one_n3_done", done, 1);
      chk("one_n3_fault", fault, 1);
      @(negedge clk);
      chk("one_cnt", cnt, 1);
      chk("one_tos", stk_tos, 3);

      // Empty-stack ADD, DROP, EQZ
      do_reset();
      for (int i = 0; i < 3; i++) begin
         logic [3:0] op;
         op = (i == 0) ? 4'd0 : (i == 1) ? 4'd9 : 4'd7;
         issue(op, 8'd0);
         chk($sformatf("empty%0d_n1_op", op), stk_op, 0);
         chk($sformatf("empty%0d_n1_done", op), done, 0);
         @(negedge clk);
         chk($sformatf("empty%0d_n2_done", op), done, 1);
         chk($sformatf("empty%0d_n2_fault", op), fault, 1);
         chk($sformatf("empty%0d_n2_op", op), stk_op, 0);
      end

      // CONST until full, overflow, illegal opcode
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue(4'd8, 8'h5A);
         chk($sformatf("fill%0d_op", i), stk_op, 1);
         chk($sformatf("fill%0d_data", i), stk_data, 8'h5A);
         @(negedge clk);
         chk($sformatf("fill%0d_fault", i), fault, 0);
      end
      issue(4'd8, 8'h5A);
      chk("full_n1_op", stk_op, 0);
      @(negedge clk);
      chk("full_n2_done", done, 1);
      chk("full_n2_fault", fault, 2);
      chk("full_cnt", cnt, 4);
      run_cmd(4'd12, 8'd0, lat, f);
      chk("illegal_lat", lat, 2);
      chk("illegal_fault", f, 3);

      // Reset in the middle of a binary op
      do_reset();
      run_cmd(4'd8, 8'd1, lat, f); run_cmd(4'd8, 8'd2, lat, f);
      issue(4'd0, 8'd0);
      chk("abort_n1_op", stk_op, 2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_ready", ready, 1);
      chk("abort_op", stk_op, 0);
      seen = done;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      chk("abort_no_done", seen, 0);
      run_cmd(4'd8, 8'd4, lat, f); run_cmd(4'd8, 8'd6, lat, f);
      run_cmd(4'd0, 8'd0, lat, f);
      chk("after_abort_lat", lat, 3);
      chk("after_abort_fault", f, 0);
      @(negedge clk);
      chk("after_abort_tos", stk_tos, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
